// File: rtl/ym3438_ch_seq.sv
// ym3438_ch_seq
// Slot sequencer for the channel accumulator / DAC output stage. Walks the
// 24-slot operator frame (6 channels x 4 operators, operator order 1,3,2,4)
// and produces registered per-slot controls decoded from the upcoming slot.
module ym3438_ch_seq #(
    parameter int NSLOT   = 24,
    parameter int DAC_WIN = 4
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        c2,
    input  logic        halt,
    input  logic        sync,
    input  logic [17:0] alg,
    output logic [4:0]  slot,
    output logic [2:0]  ch_idx,
    output logic [1:0]  op_idx,
    output logic        op1_sel,
    output logic        op_out,
    output logic        fsm_dac_load,
    output logic        fsm_dac_out_sel,
    output logic        fsm_dac_ch6,
    output logic        frame_tick
);

    // Derived frame geometry. The chip timing pins these to 24 slots,
    // 6 channels and 4-slot DAC windows.
    localparam logic [4:0] LAST_SLOT = 5'(NSLOT - 1);
    localparam logic [4:0] NCH       = 5'(NSLOT / DAC_WIN);
    localparam logic [4:0] WIN       = 5'(DAC_WIN);
    localparam logic [4:0] HALF_SLOT = 5'(NSLOT / 2);
    localparam logic [4:0] LAST_WIN  = 5'(NSLOT / DAC_WIN - 1);

    // The counter rests on the last slot after reset, so the first c2
    // lands on slot 0 and counts as a frame wrap.
    logic [4:0] slotCnt_q;
    logic [4:0] slot_q;
    logic [2:0] chIdx_q;
    logic [1:0] opIdx_q;
    logic       op1Sel_q;
    logic       opOut_q;
    logic       dacLoad_q;
    logic       dacOutSel_q;
    logic       dacCh6_q;
    logic       frameTick_q;

    logic       advance;
    logic [4:0] slotCnt_d;
    logic [4:0] chFull;
    logic [4:0] grpFull;
    logic [2:0] chIdx_d;
    logic [1:0] opIdx_d;
    logic [2:0] algSel;
    logic       op1Sel_d;
    logic       opOut_d;
    logic       dacLoad_d;
    logic       dacOutSel_d;
    logic       dacCh6_d;
    logic       frameTick_d;

    // Next-slot selection and decode of every per-slot control from it;
    // sync wins over halt, but only when accompanied by c2.
    always_comb begin
        advance     = c2 && (sync || !halt);
        slotCnt_d   = slotCnt_q;
        chFull      = 5'd0;
        grpFull     = 5'd0;
        chIdx_d     = 3'd0;
        opIdx_d     = 2'd0;
        algSel      = 3'd0;
        op1Sel_d    = 1'b0;
        opOut_d     = 1'b0;
        dacLoad_d   = 1'b0;
        dacOutSel_d = 1'b0;
        dacCh6_d    = 1'b0;
        frameTick_d = 1'b0;

        if (sync) begin
            slotCnt_d = 5'd0;
        end else if (slotCnt_q == LAST_SLOT) begin
            slotCnt_d = 5'd0;
        end else begin
            slotCnt_d = slotCnt_q + 5'd1;
        end

        chFull  = slotCnt_d % NCH;
        grpFull = slotCnt_d / NCH;
        chIdx_d = chFull[2:0];
        opIdx_d = grpFull[1:0];

        case (chIdx_d)
            3'd0:    algSel = alg[2:0];
            3'd1:    algSel = alg[5:3];
            3'd2:    algSel = alg[8:6];
            3'd3:    algSel = alg[11:9];
            3'd4:    algSel = alg[14:12];
            3'd5:    algSel = alg[17:15];
            default: algSel = 3'd0;
        endcase

        // Operator groups run op1, op3, op2, op4, so group 1 is op3 and
        // group 2 is op2 when mapping the carrier sets below.
        case (algSel)
            3'd4:       opOut_d = (opIdx_d == 2'd2) || (opIdx_d == 2'd3);
            3'd5, 3'd6: opOut_d = (opIdx_d != 2'd0);
            3'd7:       opOut_d = 1'b1;
            default:    opOut_d = (opIdx_d == 2'd3);
        endcase

        op1Sel_d    = (slotCnt_d < NCH);
        dacLoad_d   = ((slotCnt_d % WIN) == 5'd0);
        dacOutSel_d = (slotCnt_d >= HALF_SLOT);
        dacCh6_d    = ((slotCnt_d / WIN) == LAST_WIN);
        frameTick_d = (slotCnt_q == LAST_SLOT) && (slotCnt_d == 5'd0);
    end

    // Slot counter and output registers; everything holds between advances
    // except the frame tick, which is a single-MCLK pulse.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            slotCnt_q   <= LAST_SLOT;
            slot_q      <= 5'd0;
            chIdx_q     <= 3'd0;
            opIdx_q     <= 2'd0;
            op1Sel_q    <= 1'b0;
            opOut_q     <= 1'b0;
            dacLoad_q   <= 1'b0;
            dacOutSel_q <= 1'b0;
            dacCh6_q    <= 1'b0;
            frameTick_q <= 1'b0;
        end else if (advance) begin
            slotCnt_q   <= slotCnt_d;
            slot_q      <= slotCnt_d;
            chIdx_q     <= chIdx_d;
            opIdx_q     <= opIdx_d;
            op1Sel_q    <= op1Sel_d;
            opOut_q     <= opOut_d;
            dacLoad_q   <= dacLoad_d;
            dacOutSel_q <= dacOutSel_d;
            dacCh6_q    <= dacCh6_d;
            frameTick_q <= frameTick_d;
        end else begin
            frameTick_q <= 1'b0;
        end
    end

    assign slot            = slot_q;
    assign ch_idx          = chIdx_q;
    assign op_idx          = opIdx_q;
    assign op1_sel         = op1Sel_q;
    assign op_out          = opOut_q;
    assign fsm_dac_load    = dacLoad_q;
    assign fsm_dac_out_sel = dacOutSel_q;
    assign fsm_dac_ch6     = dacCh6_q;
    assign frame_tick      = frameTick_q;

endmodule

// File: tb/tb_ym3438_ch_seq.sv
// tb_ym3438_ch_seq
// Directed scenarios followed by a randomized run, all compared against a
// frame-level model of the slot sequencer.
module tb_ym3438_ch_seq;

    logic        MCLK;
    logic        reset;
    logic        c2;
    logic        halt;
    logic        sync;
    logic [17:0] alg;
    logic [4:0]  slot;
    logic [2:0]  ch_idx;
    logic [1:0]  op_idx;
    logic        op1_sel;
    logic        op_out;
    logic        fsm_dac_load;
    logic        fsm_dac_out_sel;
    logic        fsm_dac_ch6;
    logic        frame_tick;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: the internal position within the frame plus
    // the output values the stage should be presenting.
    int expCnt;
    int expSlot, expCh, expOp;
    int expOp1, expOpOut, expLoad, expOutSel, expCh6, expTick;
    int tickSeen;

    int opOfGroup [4] = '{1, 3, 2, 4};

    ym3438_ch_seq dut (
        .MCLK            (MCLK),
        .reset           (reset),
        .c2              (c2),
        .halt            (halt),
        .sync            (sync),
        .alg             (alg),
        .slot            (slot),
        .ch_idx          (ch_idx),
        .op_idx          (op_idx),
        .op1_sel         (op1_sel),
        .op_out          (op_out),
        .fsm_dac_load    (fsm_dac_load),
        .fsm_dac_out_sel (fsm_dac_out_sel),
        .fsm_dac_ch6     (fsm_dac_ch6),
        .frame_tick      (frame_tick)
    );

    // Free-running master clock.
    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    function automatic int isCarrier(input int s, input logic [17:0] a);
        int ch;
        int algNum;
        int op;
        ch     = s % 6;
        algNum = int'((a >> (3 * ch)) & 18'd7);
        op     = opOfGroup[s / 6];
        if (algNum <= 3)      return (op == 4) ? 1 : 0;
        else if (algNum == 4) return (op == 2 || op == 4) ? 1 : 0;
        else if (algNum <= 6) return (op >= 2) ? 1 : 0;
        else                  return 1;
    endfunction

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] expv);
        assertCount++;
        assert (got === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".slot"},     8'(slot),            8'(expSlot));
        checkVal({tag, ".ch_idx"},   8'(ch_idx),          8'(expCh));
        checkVal({tag, ".op_idx"},   8'(op_idx),          8'(expOp));
        checkVal({tag, ".op1_sel"},  8'(op1_sel),         8'(expOp1));
        checkVal({tag, ".op_out"},   8'(op_out),          8'(expOpOut));
        checkVal({tag, ".dac_load"}, 8'(fsm_dac_load),    8'(expLoad));
        checkVal({tag, ".out_sel"},  8'(fsm_dac_out_sel), 8'(expOutSel));
        checkVal({tag, ".dac_ch6"},  8'(fsm_dac_ch6),     8'(expCh6));
        checkVal({tag, ".tick"},     8'(frame_tick),      8'(expTick));
    endtask

    // Drive one MCLK worth of inputs, advance the model by the same rules,
    // then compare one time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic c, input logic h,
                                 input logic s, input string tag);
        int prev;
        reset = r;
        c2    = c;
        halt  = h;
        sync  = s;
        if (r) begin
            expCnt = 23;
            expSlot = 0; expCh = 0; expOp = 0; expOp1 = 0; expOpOut = 0;
            expLoad = 0; expOutSel = 0; expCh6 = 0; expTick = 0;
        end else if (c && (s || !h)) begin
            prev      = expCnt;
            expCnt    = s ? 0 : (expCnt + 1) % 24;
            expSlot   = expCnt;
            expCh     = expCnt % 6;
            expOp     = expCnt / 6;
            expOp1    = (expCnt <= 5) ? 1 : 0;
            expOpOut  = isCarrier(expCnt, alg);
            expLoad   = (expCnt % 4 == 0) ? 1 : 0;
            expOutSel = (expCnt >= 12) ? 1 : 0;
            expCh6    = (expCnt / 4 == 5) ? 1 : 0;
            expTick   = (prev == 23 && expCnt == 0) ? 1 : 0;
        end else begin
            expTick = 0;
        end
        @(posedge MCLK);
        #1;
        checkOutput(tag);
        if (frame_tick === 1'b1) tickSeen++;
    endtask

    task automatic advanceTo(input int target, input string tag);
        for (int i = 0; i < 30 && expCnt != target; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, tag);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        reset = 1'b1; c2 = 1'b0; halt = 1'b0; sync = 1'b0; alg = '0;
        tickSeen = 0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset");

        // Two full frames with every channel on algorithm 4.
        alg = {6{3'd4}};
        tickSeen = 0;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "frames");
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "frames_gap");
        end
        checkVal("tick_count", 8'(tickSeen), 8'd2);

        // Channel 2 on algorithm 7, others on 0.
        alg = 18'd7 << 6;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "alg7");
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "alg7_gap");
        end

        // Halt at slot 9, then release, then halt together with sync.
        alg = 18'($urandom);
        advanceTo(9, "to9");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "halt");
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "halt_gap");
        end
        checkVal("halt_slot", 8'(slot), 8'd9);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "release");
        checkVal("release_slot", 8'(slot), 8'd10);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "halt_sync");
        checkVal("halt_sync_slot", 8'(slot), 8'd0);

        // Sync mid-frame versus sync from the last slot.
        advanceTo(17, "to17");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "sync17");
        checkVal("sync17_tick", 8'(frame_tick), 8'd0);
        advanceTo(23, "to23");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "sync23");
        checkVal("sync23_tick", 8'(frame_tick), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "sync23_after");
        checkVal("sync23_tick_end", 8'(frame_tick), 8'd0);

        // Sync without c2 must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "sync_noc2");

        // Reset mid-frame, coincident with c2 and sync.
        advanceTo(15, "to15");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "reset15");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "post_reset");
        checkVal("post_reset_op1", 8'(op1_sel), 8'd1);
        checkVal("post_reset_load", 8'(fsm_dac_load), 8'd1);

        // Randomized run: occasional halt, sync, reset and alg changes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) alg = 18'($urandom);
            applyStimulus(($urandom_range(0, 127) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 15) == 0),
                          "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
